// File: rtl/idma_arb_pkg.sv
// Shared configuration for the iDMA stream arbiter: parameter limits, route-index
// width helper and the grant-lock state encoding.
package idma_arb_pkg;

  localparam int unsigned NUM_REQ_MIN         = 2;
  localparam int unsigned NUM_REQ_MAX         = 8;
  localparam int unsigned MAX_OUTSTANDING_MIN = 2;
  localparam int unsigned MAX_OUTSTANDING_MAX = 16;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_e;

  // Width of a requester index; never zero so a single-bit index still exists.
  function automatic int unsigned route_idx_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/idma_stream_arbiter_if.sv
// Route bookkeeping channel between the arbiter (master) and its route FIFO
// (slave): push/pop of requester indices plus occupancy status.
interface idma_stream_arbiter_if #(
  parameter int unsigned IdxWidth = 1,
  parameter int unsigned CntWidth = 3
);

  logic                push;
  logic [IdxWidth-1:0] push_idx;
  logic                pop;
  logic [IdxWidth-1:0] head_idx;
  logic                full;
  logic                empty;
  logic [CntWidth-1:0] usage;

  modport master (
    output push, push_idx, pop,
    input  head_idx, full, empty, usage
  );

  modport slave (
    input  push, push_idx, pop,
    output head_idx, full, empty, usage
  );

endinterface

// File: rtl/idma_route_fifo.sv
// Circular FIFO of requester indices, one entry per backend transfer in flight.
// Depth must be a power of two so the pointers wrap naturally.
module idma_route_fifo #(
  parameter int unsigned IdxWidth = 1,
  parameter int unsigned Depth    = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  idma_stream_arbiter_if.slave route
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [IdxWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] usage_q;

  // NOTE: storage is deliberately left out of reset; only pointers and the count
  // define validity, so clearing the array would cost reset fan-out for nothing.
  always_ff @(posedge clk_i) begin
    if (route.push) mem_q[wr_ptr_q] <= route.push_idx;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (route.push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (route.pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      unique case ({route.push, route.pop})
        2'b10:   usage_q <= usage_q + CntWidth'(1);
        2'b01:   usage_q <= usage_q - CntWidth'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  assign route.head_idx = mem_q[rd_ptr_q];
  assign route.full     = (usage_q == CntWidth'(Depth));
  assign route.empty    = (usage_q == '0);
  assign route.usage    = usage_q;

endmodule

// File: rtl/idma_stream_arbiter.sv
// Round-robin arbiter of NumReq iDMA request streams onto one backend, with
// in-order response routing. Define IDMA_STREAM_ARB_PERF_EN for perf counters.
module idma_stream_arbiter
  import idma_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = logic
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  idma_req_t                       req_i [NumReq],
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  output idma_rsp_t                       rsp_o,
  output logic [NumReq-1:0]               rsp_valid_o,
  input  logic [NumReq-1:0]               rsp_ready_i,
  output idma_req_t                       be_req_o,
  output logic                            be_req_valid_o,
  input  logic                            be_req_ready_i,
  input  idma_rsp_t                       be_rsp_i,
  input  logic                            be_rsp_valid_i,
  output logic                            be_rsp_ready_o,
  output logic                            busy_o,
  output logic [$clog2(MaxOutstanding):0] outstanding_o
`ifdef IDMA_STREAM_ARB_PERF_EN
  ,
  output logic [NumReq-1:0][31:0]         grant_cnt_o,
  output logic [31:0]                     stall_cnt_o
`endif
);

  localparam int unsigned IdxWidth = route_idx_width(NumReq);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;

  typedef logic [IdxWidth-1:0] idx_t;

  arb_state_e  state_q, state_d;
  idx_t        lock_idx_q, lock_idx_d;
  idx_t        last_grant_q, last_grant_d;
  idx_t        rr_idx;
  idx_t        winner;
  logic        rr_found;
  logic        win_valid;
  logic        room;
  logic        pop;
  int unsigned cand;

  idma_stream_arbiter_if #(.IdxWidth(IdxWidth), .CntWidth(CntWidth)) route ();

  idma_route_fifo #(
    .IdxWidth (IdxWidth),
    .Depth    (MaxOutstanding)
  ) i_route_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .route  (route)
  );

  // Priority pointer starts at NumReq-1 so requester 0 is first after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_FREE;
      lock_idx_q   <= '0;
      last_grant_q <= idx_t'(NumReq - 1);
    end else begin
      state_q      <= state_d;
      lock_idx_q   <= lock_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A presented-but-unaccepted request pins the winner until its handshake.
  always_comb begin
    state_d      = state_q;
    lock_idx_d   = lock_idx_q;
    last_grant_d = last_grant_q;
    if (be_req_valid_o && be_req_ready_i) begin
      state_d      = ARB_FREE;
      last_grant_d = winner;
    end else if (be_req_valid_o) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = winner;
    end else begin
      state_d = ARB_FREE;
    end
  end

  // NOTE: every output of a combinational block gets a default at the top so no
  // path through the if/for structure can leave a latch behind.
  always_comb begin
    rr_found = 1'b0;
    cand     = (32'(last_grant_q) + 32'd1) % NumReq;
    rr_idx   = idx_t'(cand);
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = (32'(last_grant_q) + i) % NumReq;
      if (!rr_found && req_valid_i[idx_t'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = idx_t'(cand);
      end
    end

    if (state_q == ARB_LOCKED) begin
      winner    = lock_idx_q;
      win_valid = req_valid_i[lock_idx_q];
    end else begin
      winner    = rr_idx;
      win_valid = rr_found;
    end

    // A response retiring this cycle frees the slot a full FIFO needs.
    pop  = be_rsp_valid_i && !route.empty && rsp_ready_i[route.head_idx];
    room = !route.full || pop;

    be_req_valid_o      = win_valid && room;
    be_req_o            = req_i[winner];
    req_ready_o         = '0;
    req_ready_o[winner] = be_req_ready_i && room;

    // With nothing in flight a stray response is swallowed rather than stalling.
    rsp_valid_o    = '0;
    be_rsp_ready_o = 1'b1;
    if (!route.empty) begin
      rsp_valid_o[route.head_idx] = be_rsp_valid_i;
      be_rsp_ready_o              = rsp_ready_i[route.head_idx];
    end
  end

  assign route.push     = be_req_valid_o && be_req_ready_i;
  assign route.push_idx = winner;
  assign route.pop      = pop;

  assign rsp_o         = be_rsp_i;
  assign outstanding_o = route.usage;
  assign busy_o        = (route.usage != '0) || (|req_valid_i);

`ifdef IDMA_STREAM_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (route.push) grant_cnt_o[winner] <= grant_cnt_o[winner] + 32'd1;
      if ((|req_valid_i) && !room) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) be_rsp_valid_i |-> !route.empty)
    else $error("idma_stream_arbiter: backend response with no transfer in flight");
`endif

endmodule

// File: tb/tb_idma_stream_arbiter.sv
// Directed bench for idma_stream_arbiter (NumReq=2, MaxOutstanding=4): arbitration,
// grant lock, FIFO-full stall, response ordering, mid-run reset and perf counters.
module tb_idma_stream_arbiter;

  typedef logic [15:0] req_t;
  typedef logic [15:0] rsp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  req_t       req [2];
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  rsp_t       rsp;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  req_t       be_req;
  logic       be_req_valid;
  logic       be_req_ready = 1'b1;
  rsp_t       be_rsp = '0;
  logic       be_rsp_valid = 1'b0;
  logic       be_rsp_ready;
  logic       busy;
  logic [2:0] outstanding;
`ifdef IDMA_STREAM_ARB_PERF_EN
  logic [1:0][31:0] grant_cnt;
  logic [31:0]      stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idma_stream_arbiter #(
    .NumReq         (2),
    .MaxOutstanding (4),
    .idma_req_t     (req_t),
    .idma_rsp_t     (rsp_t)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .rsp_o          (rsp),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .be_req_o       (be_req),
    .be_req_valid_o (be_req_valid),
    .be_req_ready_i (be_req_ready),
    .be_rsp_i       (be_rsp),
    .be_rsp_valid_i (be_rsp_valid),
    .be_rsp_ready_o (be_rsp_ready),
    .busy_o         (busy),
    .outstanding_o  (outstanding)
`ifdef IDMA_STREAM_ARB_PERF_EN
    ,
    .grant_cnt_o    (grant_cnt),
    .stall_cnt_o    (stall_cnt)
`endif
  );

  // Retire every in-flight transfer; only asserts be_rsp_valid while something is queued.
  task automatic drain(input string tag);
    rsp_ready = 2'b11;
    be_rsp_valid = (outstanding != 3'd0);
    for (int k = 0; k < 16 && outstanding != 3'd0; k++) begin
      @(negedge clk);
      be_rsp_valid = (outstanding != 3'd0);
    end
    be_rsp_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL %s drain: outstanding %0d expected 0", tag, outstanding); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (be_req_valid !== 1'b0) begin errors++; $display("FAIL reset be_req_valid: got %b expected 0", be_req_valid); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (be_rsp_ready !== 1'b1) begin errors++; $display("FAIL reset be_rsp_ready: got %b expected 1", be_rsp_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset outstanding: got %0d expected 0", outstanding); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  // Both requesters always valid: grants alternate 0,1,0,1 then the FIFO fills.
  task automatic test_round_robin();
    logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    req[0] = 16'hA000; req[1] = 16'hB001;
    req_valid = 2'b11; be_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL rr grant %0d: ready %b expected %b", c, req_ready, exp_rdy[c]); end
      checks++; if (be_req !== (exp_rdy[c][0] ? 16'hA000 : 16'hB001)) begin errors++; $display("FAIL rr data %0d: got %h", c, be_req); end
      @(negedge clk);
    end
    #1;
    checks++; if ({be_req_valid, req_ready} !== 3'b000) begin errors++; $display("FAIL rr full stall: valid/ready %b expected 000", {be_req_valid, req_ready}); end
    req_valid = 2'b00;
    drain("rr");
  endtask

  // Requester 1 presents alone while the backend stalls; requester 0 must not steal.
  task automatic test_lock();
    req[0] = 16'h0A0A; req[1] = 16'h1B1B;
    req_valid = 2'b10; be_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({be_req_valid, be_req} !== {1'b1, 16'h1B1B}) begin errors++; $display("FAIL lock hold %0d: valid %b data %h expected 1 1b1b", c, be_req_valid, be_req); end
      @(negedge clk);
      req_valid = 2'b11;
    end
    be_req_ready = 1'b1;
    #1;
    checks++; if ({req_ready, be_req} !== {2'b10, 16'h1B1B}) begin errors++; $display("FAIL lock handshake: ready %b data %h expected 10 1b1b", req_ready, be_req); end
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    checks++; if ({req_ready, be_req} !== {2'b01, 16'h0A0A}) begin errors++; $display("FAIL lock next: ready %b data %h expected 01 0a0a", req_ready, be_req); end
    @(negedge clk);
    req_valid = 2'b00;
    drain("lock");
  endtask

  task automatic test_full();
    req_valid = 2'b01; be_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full outstanding: got %0d expected 4", outstanding); end
    checks++; if ({be_req_valid, req_ready, busy} !== 4'b0001) begin errors++; $display("FAIL full stall: valid/ready/busy %b expected 0001", {be_req_valid, req_ready, busy}); end
    @(negedge clk);
    be_rsp_valid = 1'b1; be_rsp = 16'h5555;
    #1;
    checks++; if ({rsp_valid, be_rsp_ready} !== 3'b011) begin errors++; $display("FAIL full rsp route: rsp_valid/be_rsp_ready %b expected 011", {rsp_valid, be_rsp_ready}); end
    checks++; if ({be_req_valid, req_ready} !== 3'b101) begin errors++; $display("FAIL full push-with-pop: valid/ready %b expected 101", {be_req_valid, req_ready}); end
    @(negedge clk);
    be_rsp_valid = 1'b0; req_valid = 2'b00;
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full push+pop count: got %0d expected 4", outstanding); end
    drain("full");
  endtask

  // Issue 1,0,1 then verify responses come back on 1,0,1 with back-pressure on 0.
  task automatic test_order();
    logic [1:0] seq [3] = '{2'b10, 2'b01, 2'b10};
    be_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_valid = seq[c];
      #1;
      checks++; if (req_ready !== seq[c]) begin errors++; $display("FAIL order issue %0d: ready %b expected %b", c, req_ready, seq[c]); end
      @(negedge clk);
    end
    req_valid = 2'b00; be_rsp_valid = 1'b1; be_rsp = 16'h0111; rsp_ready = 2'b11;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL order outstanding: got %0d expected 3", outstanding); end
    checks++; if ({rsp_valid, rsp} !== {2'b10, 16'h0111}) begin errors++; $display("FAIL order rsp0: valid %b data %h expected 10 0111", rsp_valid, rsp); end
    @(negedge clk);
    rsp_ready = 2'b10;
    #1;
    checks++; if ({rsp_valid, be_rsp_ready} !== 3'b010) begin errors++; $display("FAIL order backpressure: valid/ready %b expected 010", {rsp_valid, be_rsp_ready}); end
    @(negedge clk);
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL order held: outstanding %0d expected 2", outstanding); end
    rsp_ready = 2'b11;
    #1;
    checks++; if ({rsp_valid, be_rsp_ready} !== 3'b011) begin errors++; $display("FAIL order rsp1: valid/ready %b expected 011", {rsp_valid, be_rsp_ready}); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL order rsp2: valid %b expected 10", rsp_valid); end
    @(negedge clk);
    be_rsp_valid = 1'b0;
    #1;
    checks++; if ({outstanding, be_rsp_ready} !== 4'b0001) begin errors++; $display("FAIL order empty: outstanding/ready %b expected 0001", {outstanding, be_rsp_ready}); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    req_valid = 2'b11; be_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL mrst before: outstanding %0d expected 3", outstanding); end
    rst_n = 1'b0;
    #1;
    checks++; if ({outstanding, busy} !== 4'b0000) begin errors++; $display("FAIL mrst clear: outstanding/busy %b expected 0000", {outstanding, busy}); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mrst priority: ready %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    drain("mrst");
  endtask

`ifdef IDMA_STREAM_ARB_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    req_valid = 2'b01; be_req_ready = 1'b1;
    repeat (6) @(negedge clk);
    be_rsp_valid = 1'b1;
    @(negedge clk);
    be_rsp_valid = 1'b0; req_valid = 2'b00;
    #1;
    checks++; if (grant_cnt[0] !== 32'd5) begin errors++; $display("FAIL perf grant0: got %0d expected 5", grant_cnt[0]); end
    checks++; if (grant_cnt[1] !== 32'd0) begin errors++; $display("FAIL perf grant1: got %0d expected 0", grant_cnt[1]); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL perf stall: got %0d expected 2", stall_cnt); end
    drain("perf");
  endtask
`endif

  initial begin
    req[0] = '0; req[1] = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_order();
    test_mid_reset();
`ifdef IDMA_STREAM_ARB_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/idma_stream_arbiter.md
IDMA_STREAM_ARBITER -- requirements
Module: idma_stream_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, meaning number of upstream requesters (2..8).
REQ-002 SHALL have parameter MaxOutstanding, default 4, meaning maximum backend transfers in flight (power of two, 2..16).
REQ-003 SHALL have parameter idma_req_t, default logic, meaning 1D backend request type.
REQ-004 SHALL have parameter idma_rsp_t, default logic, meaning backend response type.
REQ-005 SHALL have ports clk_i (input, 1, clock) and rst_ni (input, 1, reset); one clock, reset asynchronous and active-low.
REQ-006 SHALL have ports req_i (input, NumReq x idma_req_t, requests), req_valid_i (input, NumReq, valids) and req_ready_o (output, NumReq, readies).
REQ-007 SHALL have ports rsp_o (output, idma_rsp_t, response, shared) with rsp_valid_o (output, NumReq) and rsp_ready_i (input, NumReq).
REQ-008 SHALL have ports be_req_o (output, idma_req_t), be_req_valid_o (output, 1) and be_req_ready_i (input, 1), toward the backend.
REQ-009 SHALL have ports be_rsp_i (input, idma_rsp_t), be_rsp_valid_i (input, 1) and be_rsp_ready_o (output, 1), from the backend.
REQ-010 SHALL have ports busy_o (output, 1, transfers in flight or request pending) and outstanding_o (output, $clog2(MaxOutstanding)+1, in-flight count).

Function
REQ-011 SHALL arbitrate round-robin: the first valid requester after last_grant (wrapping) wins; after reset, requester 0 has priority.
REQ-012 SHALL lock the grant while be_req_valid_o=1 and be_req_ready_i=0; be_req_o and the winner stay stable until the handshake, even if other valids rise.
REQ-013 SHALL be a combinational path, zero-latency: be_req_valid_o = winner valid AND route FIFO not full; req_ready_o[winner] = be_req_ready_i AND not full; all other readies 0.
REQ-014 SHALL, on each be_req handshake, push the winner index into a MaxOutstanding-deep route FIFO and update last_grant the next cycle.
REQ-015 SHALL, when route FIFO is full, hold be_req_valid_o=0 and all req_ready_o=0.
REQ-016 SHALL route be_rsp_i to the requester at FIFO head: rsp_valid_o[head] = be_rsp_valid_i, be_rsp_ready_o = rsp_ready_i[head], others 0; pop on handshake.
REQ-017 SHALL treat be_rsp_valid_i with an empty FIFO as a protocol error: be_rsp_ready_o=1 (drop) and, in simulation, an assertion fires.
REQ-018 SHALL, on simultaneous push and pop, keep outstanding_o unchanged; allow push when full only if a pop occurs the same cycle.
REQ-019 SHALL assert busy_o when outstanding_o != 0 or any req_valid_i is high.
REQ-020 SHALL keep outstanding_o saturating-free: it never exceeds MaxOutstanding nor underflows.

Reset
REQ-021 SHALL, on rst_ni low, asynchronously clear FIFO pointers, outstanding_o=0, last_grant=NumReq-1, grant lock=0, and, with the perf macro, all counters.
REQ-022 SHALL drive after reset: be_req_valid_o=0 (absent valids), rsp_valid_o=0, be_rsp_ready_o=1 (empty-FIFO drop), busy_o=0.
REQ-023 SHALL discard in-flight routing state on mid-operation reset; upstream/backend are reset together by the system.

Configuration
REQ-024 SHALL, with IDMA_STREAM_ARB_PERF_EN defined, add output grant_cnt_o (NumReq x 32, per-requester accepted requests, wrapping at 2^32) and stall_cnt_o (32, cycles with valid request but FIFO full).
REQ-025 SHALL, without IDMA_STREAM_ARB_PERF_EN, omit those ports and counters entirely.

Structure
REQ-026 SHALL place the NumReq/MaxOutstanding limits and the route-index width function in shared package idma_arb_pkg.
REQ-027 SHALL implement the route FIFO as sub-module idma_route_fifo (index width, depth parameters; push/pop/full/empty/usage).

Verification
REQ-028 SHALL cover: req 0 and 1 valid continuously, be_req_ready_i=1 -> grants 0,1,0,1 on consecutive cycles.
REQ-029 SHALL cover: req 1 wins, be_req_ready_i=0 for 3 cycles while req 0 rises -> be_req_o holds req 1's value, grant 1 until handshake.
REQ-030 SHALL cover: 4 accepted requests, no responses, MaxOutstanding=4 -> outstanding_o=4, 5th request stalled (ready 0); one response -> 5th accepted the same cycle.
REQ-031 SHALL cover: issue order 1,0,1 -> three responses delivered on rsp_valid_o[1], [0], [1] in order; rsp_ready_i[0]=0 back-pressures be_rsp_ready_o.
REQ-032 SHALL cover: rst_ni pulsed low with 3 in flight -> outstanding_o=0, busy_o=0, next grant goes to requester 0.
REQ-033 SHALL cover: with IDMA_STREAM_ARB_PERF_EN, 5 grants to requester 0 and 2 full-stall cycles -> grant_cnt_o[0]=5, stall_cnt_o=2.
